// File: rtl/serial_dft_multibin.sv
// -----------------------------------------------------------------------------
// serial_dft_multibin
//
// Streaming serial DFT engine. Each accepted real sample x[n] is multiplied by
// a per-bin, per-index complex twiddle and accumulated in one MAC per bin.
// When the last sample of a frame is accepted, all bins are copied into an
// output buffer and streamed out one bin per transfer, while the next frame
// keeps accumulating.
//
// Ports
//   clk      : clock, all logic on the rising edge
//   arstn    : asynchronous active-low reset
//   w_re     : twiddle real parts, entry k*FRAME_LENGTH+n is bin k, sample n
//   w_im     : twiddle imaginary parts, same indexing
//   valid_i  : input sample valid
//   ready_o  : block can accept a sample this cycle
//   x        : signed input sample
//   flush_i  : drop the partial frame (restart at sample index 0)
//   valid_o  : output bin valid
//   ready_i  : downstream accepts the bin
//   re, im   : signed real/imaginary part of the current bin
//   bin_o    : index of the current bin
//   last_o   : high with the final bin of a frame
// -----------------------------------------------------------------------------
module serial_dft_multibin #(
    parameter int W_WIDTH      = 16,
    parameter int X_WIDTH      = 16,
    parameter int S_WIDTH      = 40,
    parameter int FRAME_LENGTH = 8,
    parameter int NUM_BINS     = 4,
    localparam int BIN_W       = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1
) (
    input  logic                      clk,
    input  logic                      arstn,
    input  logic signed [W_WIDTH-1:0] w_re [NUM_BINS*FRAME_LENGTH],
    input  logic signed [W_WIDTH-1:0] w_im [NUM_BINS*FRAME_LENGTH],
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic signed [X_WIDTH-1:0] x,
    input  logic                      flush_i,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic signed [S_WIDTH-1:0] re,
    output logic signed [S_WIDTH-1:0] im,
    output logic [BIN_W-1:0]          bin_o,
    output logic                      last_o
);

    localparam int N_W     = $clog2(FRAME_LENGTH);
    localparam int P_WIDTH = W_WIDTH + X_WIDTH;

    localparam logic [N_W-1:0]   LAST_N   = N_W'(FRAME_LENGTH - 1);
    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NUM_BINS - 1);

    logic [N_W-1:0] n;

    logic signed [S_WIDTH-1:0] acc_re  [NUM_BINS];
    logic signed [S_WIDTH-1:0] acc_im  [NUM_BINS];
    logic signed [S_WIDTH-1:0] buf_re  [NUM_BINS];
    logic signed [S_WIDTH-1:0] buf_im  [NUM_BINS];

    logic signed [P_WIDTH-1:0] p_re    [NUM_BINS];
    logic signed [P_WIDTH-1:0] p_im    [NUM_BINS];
    logic signed [S_WIDTH-1:0] prod_re [NUM_BINS];
    logic signed [S_WIDTH-1:0] prod_im [NUM_BINS];
    logic signed [S_WIDTH-1:0] sum_re  [NUM_BINS];
    logic signed [S_WIDTH-1:0] sum_im  [NUM_BINS];

    logic             accept;
    logic             frame_end;
    logic             last_xfer;
    logic [BIN_W-1:0] nxt_bin;

    // valid_o doubles as the "output buffer holds an undrained frame" flag:
    // it is set when a frame loads and cleared only after its last bin leaves.
    assign last_xfer = valid_o && ready_i && last_o;

    // Only the closing sample of a frame can be blocked, and only while the
    // previous frame is still in the buffer. Draining its last bin on the same
    // edge frees the buffer in time for the new load.
    assign ready_o   = !flush_i && !((n == LAST_N) && valid_o && !last_xfer);
    assign accept    = valid_i && ready_o;
    assign frame_end = accept && (n == LAST_N);
    assign nxt_bin   = bin_o + 1'b1;

    always_comb begin
        for (int k = 0; k < NUM_BINS; k++) begin
            p_re[k] = '0;
            p_im[k] = '0;
            p_re[k] = P_WIDTH'(x) * P_WIDTH'(w_re[k*FRAME_LENGTH + int'(n)]);
            p_im[k] = P_WIDTH'(x) * P_WIDTH'(w_im[k*FRAME_LENGTH + int'(n)]);
            // Signed size cast sign-extends the full-precision product.
            prod_re[k] = S_WIDTH'(p_re[k]);
            prod_im[k] = S_WIDTH'(p_im[k]);
            sum_re[k]  = acc_re[k] + prod_re[k];
            sum_im[k]  = acc_im[k] + prod_im[k];
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            n       <= '0;
            valid_o <= 1'b0;
            re      <= '0;
            im      <= '0;
            bin_o   <= '0;
            last_o  <= 1'b0;
            for (int k = 0; k < NUM_BINS; k++) begin
                acc_re[k] <= '0;
                acc_im[k] <= '0;
                buf_re[k] <= '0;
                buf_im[k] <= '0;
            end
        end else begin
            // Sample side. A flush only rewinds the index; the stale
            // accumulators are overwritten by the next index-0 sample.
            if (flush_i) begin
                n <= '0;
            end else if (accept) begin
                n <= (n == LAST_N) ? '0 : n + 1'b1;
                for (int k = 0; k < NUM_BINS; k++) begin
                    acc_re[k] <= (n == '0) ? prod_re[k] : sum_re[k];
                    acc_im[k] <= (n == '0) ? prod_im[k] : sum_im[k];
                end
            end

            // Readout side. A frame load takes priority; it can only coincide
            // with the final transfer of the previous frame.
            if (frame_end) begin
                for (int k = 0; k < NUM_BINS; k++) begin
                    buf_re[k] <= sum_re[k];
                    buf_im[k] <= sum_im[k];
                end
                valid_o <= 1'b1;
                re      <= sum_re[0];
                im      <= sum_im[0];
                bin_o   <= '0;
                last_o  <= (NUM_BINS == 1);
            end else if (valid_o && ready_i) begin
                if (last_o) begin
                    valid_o <= 1'b0;
                end else begin
                    re     <= buf_re[nxt_bin];
                    im     <= buf_im[nxt_bin];
                    bin_o  <= nxt_bin;
                    last_o <= (nxt_bin == LAST_BIN);
                end
            end
        end
    end

endmodule
